// File: rtl/rvfi_bus_pkg.sv
// Shared types and helpers for the RVFI bus monitor.
// Holds the default-width request record and the byte-lane masking helper.
package rvfi_bus_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int BUSLEN_DEF    = 32;
    localparam int NLANES_DEF    = BUSLEN_DEF / 8;
    localparam int OFFS_BITS_DEF = $clog2(NLANES_DEF);

    // Widest bus the masking helper handles; narrower buses zero-extend into it.
    localparam int MAX_BUSLEN    = 1024;
    localparam int MAX_LANES     = MAX_BUSLEN / 8;

    typedef struct packed {
        logic [XLEN_DEF-1:0]   addr;
        logic [NLANES_DEF-1:0] rmask;
        logic [NLANES_DEF-1:0] wmask;
        logic [BUSLEN_DEF-1:0] wdata;
    } bus_req_t;

    function automatic logic [MAX_BUSLEN-1:0] lane_mask_data(
        input logic [MAX_BUSLEN-1:0] data,
        input logic [MAX_LANES-1:0]  mask
    );
        logic [MAX_BUSLEN-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            r[i*8 +: 8] = mask[i] ? data[i*8 +: 8] : 8'h00;
        end
        return r;
    endfunction

endpackage

// File: rtl/rvfi_bus_req_fifo.sv
// Synchronous FIFO of accepted bus requests awaiting their in-order response.
// A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
module rvfi_bus_req_fifo
    import rvfi_bus_pkg::*;
#(
    parameter type T     = bus_req_t,
    parameter int  DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/rvfi_bus_monitor.sv
// Passive valid/ready bus tap: pairs each accepted request with its in-order
// response and emits one registered RVFI bus record per completed transaction.
module rvfi_bus_monitor
    import rvfi_bus_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int BUSLEN  = BUSLEN_DEF,
    parameter int DEPTH   = 4,
    parameter bit IS_DATA = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_ready,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [BUSLEN/8-1:0] req_rmask,
    input  logic [BUSLEN/8-1:0] req_wmask,
    input  logic [BUSLEN-1:0]   req_wdata,
    input  logic                rsp_valid,
    input  logic [BUSLEN-1:0]   rsp_rdata,
    input  logic                rsp_error,
    output logic                rvfi_bus_valid,
    output logic                rvfi_bus_insn,
    output logic                rvfi_bus_data,
    output logic                rvfi_bus_fault,
    output logic [XLEN-1:0]     rvfi_bus_addr,
    output logic [BUSLEN/8-1:0] rvfi_bus_rmask,
    output logic [BUSLEN-1:0]   rvfi_bus_rdata,
    output logic [BUSLEN/8-1:0] rvfi_bus_wmask,
    output logic [BUSLEN-1:0]   rvfi_bus_wdata,
    output logic                mon_proto_err
);

    localparam int NL   = BUSLEN / 8;
    localparam int OFFS = $clog2(NL);
    localparam logic [XLEN-1:0] ALIGN = ~((XLEN'(1) << OFFS) - XLEN'(1));

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [NL-1:0]     rmask;
        logic [NL-1:0]     wmask;
        logic [BUSLEN-1:0] wdata;
    } req_t;

    logic push, full, empty, rec;
    req_t push_req, head;

    logic [MAX_BUSLEN-1:0]        wdata_full, rdata_full;
    logic [MAX_BUSLEN-BUSLEN-1:0] unused_wdata_hi, unused_rdata_hi;

    assign push = req_valid && req_ready;
    assign rec  = rsp_valid && !empty;

    assign wdata_full      = lane_mask_data(MAX_BUSLEN'(req_wdata), MAX_LANES'(req_wmask));
    assign rdata_full      = lane_mask_data(MAX_BUSLEN'(rsp_rdata), MAX_LANES'(head.rmask));
    assign unused_wdata_hi = wdata_full[MAX_BUSLEN-1:BUSLEN];
    assign unused_rdata_hi = rdata_full[MAX_BUSLEN-1:BUSLEN];

    assign push_req.addr  = req_addr & ALIGN;
    assign push_req.rmask = req_rmask;
    assign push_req.wmask = req_wmask;
    assign push_req.wdata = wdata_full[BUSLEN-1:0];

    rvfi_bus_req_fifo #(
        .T     (req_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .data_i  (push_req),
        .pop_i   (rsp_valid),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    logic              valid_q, valid_d, insn_q, insn_d, data_q, data_d;
    logic              fault_q, fault_d, err_q, err_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [NL-1:0]     rmask_q, rmask_d, wmask_q, wmask_d;
    logic [BUSLEN-1:0] rdata_q, rdata_d, wdata_q, wdata_d;

    // A response on an empty FIFO never matches a same-cycle request.
    always_comb begin
        valid_d = 1'b0;
        insn_d  = 1'b0;
        data_d  = 1'b0;
        fault_d = 1'b0;
        addr_d  = '0;
        rmask_d = '0;
        wmask_d = '0;
        rdata_d = '0;
        wdata_d = '0;
        err_d   = err_q | (rsp_valid && empty) | (push && full && !rsp_valid);
        if (rec) begin
            valid_d = 1'b1;
            insn_d  = ~IS_DATA;
            data_d  = IS_DATA;
            fault_d = rsp_error;
            addr_d  = head.addr;
            rmask_d = head.rmask;
            wmask_d = head.wmask;
            rdata_d = rdata_full[BUSLEN-1:0];
            wdata_d = head.wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            insn_q  <= 1'b0;
            data_q  <= 1'b0;
            fault_q <= 1'b0;
            addr_q  <= '0;
            rmask_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            insn_q  <= insn_d;
            data_q  <= data_d;
            fault_q <= fault_d;
            addr_q  <= addr_d;
            rmask_q <= rmask_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign rvfi_bus_valid = valid_q;
    assign rvfi_bus_insn  = insn_q;
    assign rvfi_bus_data  = data_q;
    assign rvfi_bus_fault = fault_q;
    assign rvfi_bus_addr  = addr_q;
    assign rvfi_bus_rmask = rmask_q;
    assign rvfi_bus_rdata = rdata_q;
    assign rvfi_bus_wmask = wmask_q;
    assign rvfi_bus_wdata = wdata_q;
    assign mon_proto_err  = err_q;

endmodule

// File: doc/rvfi_bus_monitor.md
Name: rvfi_bus_monitor

Overview:
- Passive tap on one core-side valid/ready memory bus.
- Converts each completed transaction (request accepted, then in-order response) into one registered RVFI bus channel record.
- Its outputs drive the `rvfi_bus_*` inputs of the bus data/instruction checks. One instance per bus channel; the wrapper concatenates instances to form NBUS channels.

Parameters:
- XLEN, 32, address width.
- BUSLEN, 32, bus data width; multiple of 8.
- DEPTH, 4, max outstanding requests; power of two, >= 2.
- IS_DATA, 1, 1 = data bus (drives rvfi_bus_data), 0 = instruction bus (drives rvfi_bus_insn).

Ports:
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  in  1  request ready (as seen on bus)
- req_addr  in  XLEN  byte address
- req_rmask  in  BUSLEN/8  read byte lanes
- req_wmask  in  BUSLEN/8  write byte lanes
- req_wdata  in  BUSLEN  write data
- rsp_valid  in  1  response beat (no backpressure)
- rsp_rdata  in  BUSLEN  read data
- rsp_error  in  1  bus fault on this response
- rvfi_bus_valid  out  1  record valid
- rvfi_bus_insn  out  1  record is instruction fetch
- rvfi_bus_data  out  1  record is data access
- rvfi_bus_fault  out  1  fault
- rvfi_bus_addr  out  XLEN  lane-0 byte address
- rvfi_bus_rmask  out  BUSLEN/8  read lanes
- rvfi_bus_rdata  out  BUSLEN  read data, masked
- rvfi_bus_wmask  out  BUSLEN/8  write lanes
- rvfi_bus_wdata  out  BUSLEN  write data, masked
- mon_proto_err  out  1  sticky protocol violation

Behaviour:
- Reset: reset is synchronous, active-high; clock is clock. FIFO empty, all outputs 0, mon_proto_err 0.
- Push: request accepted when `req_valid && req_ready`.
  - Enqueue addr aligned down to BUSLEN/8 (low log2(BUSLEN/8) bits cleared), rmask, wmask.
  - Enqueue wdata with non-wmask lanes zeroed.
- Pop: `rsp_valid` pops the oldest entry. Responses are strictly in order.
- Output timing: the record appears on the cycle after `rsp_valid`, as a one-cycle `rvfi_bus_valid` pulse; fully registered.
  - `rvfi_bus_rdata` = rsp_rdata with non-rmask lanes zeroed.
  - `rvfi_bus_fault` = rsp_error.
  - `insn`/`data` = IS_DATA encoding, qualified by valid.
- Idle: when no record is emitted, every `rvfi_bus_*` output is 0.
- Same-cycle push and pop:
  - Non-empty FIFO: pop the head and push the new request; count unchanged.
  - Empty FIFO: the response cannot match a request accepted in the same cycle. Flag error, push still occurs, no record.
- Full FIFO:
  - Push without pop: request dropped, mon_proto_err set.
  - Push with pop: both performed, legal.
- Empty FIFO with `rsp_valid`: no record, mon_proto_err set.
- Zero-mask request (rmask=0, wmask=0) is legal; it emits a record with zero masks.
- mon_proto_err is sticky until reset.
- Reset mid-transaction: outstanding entries discarded. A response arriving after reset deassertion with an empty FIFO flags error.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Count is log2(DEPTH)+1 bits, range 0..DEPTH.

Decomposition:
- rvfi_bus_pkg holds:
  - localparams for lane count and offset bits;
  - typedef `bus_req_t {addr, rmask, wmask, wdata}`;
  - function `lane_mask_data(data, mask)`.
- Sub-module rvfi_bus_req_fifo: sync FIFO of bus_req_t with push/pop/full/empty, same-cycle push+pop when full.
- Top keeps the error logic and output register.

Test Plan:
- Single read: req addr 0x1002, rmask 0b1100, response 2 cycles later with rdata 0xAABBCCDD.
  - Required: one cycle after rsp, valid=1, addr 0x1000, rmask 0b1100, rdata 0xAABB0000, fault 0.
- Write: wmask 0b0011, wdata 0x12345678, response error=1.
  - Required: wdata 0x00005678, wmask 0b0011, fault=1, rmask 0.
- Four back-to-back requests A0..A3 (FIFO full), then a fifth request with no response.
  - Required: fifth dropped, mon_proto_err=1; the next four responses emit A0..A3 in order.
- Full FIFO with same-cycle request and response.
  - Required: head record emitted, new request queued, mon_proto_err stays 0, count stays 4.
- rsp_valid with nothing outstanding, and separately request plus response in the same cycle on an empty FIFO.
  - Required: no rvfi_bus_valid pulse, mon_proto_err=1.
- Reset asserted with 2 outstanding requests, then a response after reset.
  - Required: outputs 0 during reset, no record emitted, mon_proto_err=1; with IS_DATA=0, records show insn=1, data=0.
